// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: FSM state encoding,
// SPI mode constants ({cpol, cpha}) and the default word width.
package spi_pkg;

    localparam int SPI_DATA_WIDTH_DEFAULT = 8;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_e;

endpackage

// File: rtl/spi_tick_detect.sv
// Turns the ratio clock divider's toggling output into a one-cycle tick.
// Each toggle marks one SCK half-period. The edge register is held at zero
// while the divider is disabled, so a restarted divider never produces a
// stale tick from a level left over from the previous transfer.
module spi_tick_detect (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic clear_i,
    input  logic ratio_clk_i,
    output logic tick_o
);

    logic ratio_q;

    // Remember the previous divider level; forced low while cleared.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ratio_q <= 1'b0;
        end else if (clear_i) begin
            ratio_q <= 1'b0;
        end else begin
            ratio_q <= ratio_clk_i;
        end
    end

    assign tick_o = !clear_i && (ratio_clk_i ^ ratio_q);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine for CPOL/CPHA modes 0-3.
// Each tick from the ratio clock divider is one SCK half-period. A word is
// accepted over valid/ready, shifted out MSB first on MOSI while MISO is
// shifted into a receive register, and the received word is presented with
// a one-cycle rx_valid_o pulse.
// Optional build macro SPI_LOOPBACK_EN adds loopback_i, which routes the
// engine's own MOSI back into the receive path (latched at word accept).
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH_DEFAULT,
    parameter int CNT_WIDTH  = $clog2(2*DATA_WIDTH)+1
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  en_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  ratio_en_o,
    input  logic                  ratio_clk_i,
    output logic                  sck_o,
    output logic                  mosi_o,
    input  logic                  miso_i,
`ifdef SPI_LOOPBACK_EN
    input  logic                  loopback_i,
`endif
    output logic                  ss_n_o
);

    // Half-period count at which all 2*DATA_WIDTH SCK edges have been issued.
    localparam logic [CNT_WIDTH-1:0] LAST_HALF = CNT_WIDTH'(2*DATA_WIDTH);

    spi_state_e            state;
    logic                  ready_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  tick;
    logic                  sample_bit;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [CNT_WIDTH-1:0]  half_cnt;
    logic [CNT_WIDTH-1:0]  half_next;

    spi_tick_detect u_tick_detect (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .clear_i     (!ratio_en_o),
        .ratio_clk_i (ratio_clk_i),
        .tick_o      (tick)
    );

    // The front-end may only hand over a word while the engine is enabled.
    assign tx_ready_o = ready_q && en_i;
    assign half_next  = half_cnt + CNT_WIDTH'(1);

`ifdef SPI_LOOPBACK_EN
    logic loop_q;
    assign sample_bit = loop_q ? mosi_o : miso_i;
`else
    assign sample_bit = miso_i;
`endif

    // Transfer sequencer: accept, select, clock out/in all bits, deselect, report.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            busy_o     <= 1'b0;
            ratio_en_o <= 1'b0;
            sck_o      <= 1'b0;
            mosi_o     <= 1'b0;
            ss_n_o     <= 1'b1;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            half_cnt   <= '0;
`ifdef SPI_LOOPBACK_EN
            loop_q     <= 1'b0;
`endif
        end else begin
            rx_valid_o <= 1'b0;
            if (!en_i) begin
                state      <= IDLE;
                ready_q    <= 1'b1;
                busy_o     <= 1'b0;
                ratio_en_o <= 1'b0;
                sck_o      <= cpol_i;
                mosi_o     <= 1'b0;
                ss_n_o     <= 1'b1;
                half_cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        sck_o   <= cpol_i;
                        ready_q <= 1'b1;
                        if (tx_valid_i && ready_q) begin
                            ready_q    <= 1'b0;
                            tx_sr      <= tx_data_i;
                            rx_sr      <= '0;
                            cpol_q     <= cpol_i;
                            cpha_q     <= cpha_i;
                            half_cnt   <= '0;
                            ss_n_o     <= 1'b0;
                            ratio_en_o <= 1'b1;
                            busy_o     <= 1'b1;
                            mosi_o     <= cpha_i ? 1'b0 : tx_data_i[DATA_WIDTH-1];
`ifdef SPI_LOOPBACK_EN
                            loop_q     <= loopback_i;
`endif
                            state      <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (tick) begin
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            half_cnt <= half_next;
                            sck_o    <= ~sck_o;
                            if (half_next[0]) begin
                                if (cpha_q) begin
                                    mosi_o <= tx_sr[DATA_WIDTH-1];
                                    tx_sr  <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                                end else begin
                                    rx_sr <= {rx_sr[DATA_WIDTH-2:0], sample_bit};
                                end
                            end else begin
                                if (cpha_q) begin
                                    rx_sr <= {rx_sr[DATA_WIDTH-2:0], sample_bit};
                                end else if (half_next != LAST_HALF) begin
                                    mosi_o <= tx_sr[DATA_WIDTH-2];
                                    tx_sr  <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                                end
                            end
                            if (half_next == LAST_HALF) begin
                                state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            ss_n_o     <= 1'b1;
                            ratio_en_o <= 1'b0;
                            sck_o      <= cpol_q;
                            state      <= DONE;
                        end
                    end
                    DONE: begin
                        rx_data_o  <= rx_sr;
                        rx_valid_o <= 1'b1;
                        busy_o     <= 1'b0;
                        mosi_o     <= 1'b0;
                        ready_q    <= 1'b1;
                        state      <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Testbench for spi_shift_engine: ratio divider model, mode-aware SPI slave
// model, and a scoreboard that checks every received word against a queue
// of expected words pushed when the word is issued.
// Define SPI_LOOPBACK_EN to also exercise the loopback path.
`timescale 1ns/1ps
module tb_spi_shift_engine;
    import spi_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        string        tag;
    } exp_t;

    logic         clk      = 1'b0;
    logic         arst_n   = 1'b0;
    logic         en       = 1'b0;
    logic         cpol     = 1'b0;
    logic         cpha     = 1'b0;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data  = '0;
    logic         miso     = 1'b0;
`ifdef SPI_LOOPBACK_EN
    logic         loopback = 1'b0;
`endif
    logic         tx_ready;
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         busy;
    logic         ratio_en;
    logic         sck;
    logic         mosi;
    logic         ss_n;

    int vecCount = 0;
    int errCount = 0;

    exp_t expQ[$];
    int   rxCount = 0;
    logic rxValidPrev = 1'b0;

    int   ratio = 0;
    int   rcnt;
    logic rclk;

    logic [W-1:0] slvQ[$];
    logic [W-1:0] slvTx = '0;
    logic [W-1:0] slvRx = '0;
    logic         slvSsPrev = 1'b1;
    logic         slvSckPrev = 1'b0;

    int   lowTicks = 0;
    int   sckToggles = 0;
    int   highRun = 0;
    int   lastGap = 0;
    int   readyViolations = 0;
    logic ssWasHigh = 1'b1;
    logic rclkPrev = 1'b0;
    logic sckPrev = 1'b0;

    logic [1:0] modes [3] = '{MODE1, MODE2, MODE3};

    spi_shift_engine #(.DATA_WIDTH(W)) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .en_i        (en),
        .cpol_i      (cpol),
        .cpha_i      (cpha),
        .tx_valid_i  (tx_valid),
        .tx_ready_o  (tx_ready),
        .tx_data_i   (tx_data),
        .rx_valid_o  (rx_valid),
        .rx_data_o   (rx_data),
        .busy_o      (busy),
        .ratio_en_o  (ratio_en),
        .ratio_clk_i (rclk),
        .sck_o       (sck),
        .mosi_o      (mosi),
        .miso_i      (miso),
`ifdef SPI_LOOPBACK_EN
        .loopback_i  (loopback),
`endif
        .ss_n_o      (ss_n)
    );

    always #5 clk = ~clk;

    // Ratio divider model: restarts from zero on enable, toggles every ratio+1 cycles.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n || !ratio_en) begin
            rcnt <= 0;
            rclk <= 1'b0;
        end else if (rcnt >= ratio) begin
            rcnt <= 0;
            rclk <= ~rclk;
        end else begin
            rcnt <= rcnt + 1;
        end
    end

    // SPI slave model: loads its reply at select, drives/samples on the mode's edges.
    always @(ss_n or sck) begin
        if (slvSsPrev === 1'b1 && ss_n === 1'b0) begin
            slvTx = (slvQ.size() > 0) ? slvQ.pop_front() : '0;
            slvRx = '0;
            if (!cpha) begin
                miso  = slvTx[W-1];
                slvTx = slvTx << 1;
            end
        end else if (ss_n === 1'b0 && sck !== slvSckPrev) begin
            if ((sck != cpol) != cpha) begin
                slvRx = {slvRx[W-2:0], mosi};
            end else begin
                miso  = slvTx[W-1];
                slvTx = slvTx << 1;
            end
        end
        slvSsPrev  = ss_n;
        slvSckPrev = sck;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: scoreboard for received words plus per-transfer waveform statistics.
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid === 1'b1) begin
            rxCount++;
            checkOutput("rx_valid_single_pulse", {31'd0, rxValidPrev}, 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput({e.tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, e.data});
            end
        end
        rxValidPrev = rx_valid;
        if (ss_n === 1'b0) begin
            if (ssWasHigh) begin
                lastGap    = highRun;
                lowTicks   = 0;
                sckToggles = 0;
            end
            ssWasHigh = 1'b0;
            highRun   = 0;
            if (rclk !== rclkPrev) lowTicks++;
            if (sck !== sckPrev) sckToggles++;
            if (tx_ready !== 1'b0 || busy !== 1'b1) readyViolations++;
        end else begin
            ssWasHigh = 1'b1;
            highRun++;
        end
        rclkPrev = rclk;
        sckPrev  = sck;
    end

    task automatic applyStimulus(input logic [W-1:0] word, input logic [W-1:0] expectRx,
                                 input bit push, input string tag);
        exp_t e;
        int   k = 0;
        @(negedge clk);
        tx_data  = word;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (tx_ready !== 1'b1) begin
            checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
        end else if (push) begin
            e.data = expectRx;
            e.tag  = tag;
            expQ.push_back(e);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitRx(input int target, input string tag);
        int k = 0;
        while (rxCount < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (rxCount < target) checkOutput({tag, "_rx_timeout"}, rxCount, target);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitTicks(input int n, input string tag);
        int k = 0;
        while (lowTicks < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (lowTicks < n) checkOutput({tag, "_tick_timeout"}, lowTicks, n);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd0);
        checkOutput({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        checkOutput({tag, "_rx_data"},  {24'd0, rx_data},  32'd0);
        checkOutput({tag, "_busy"},     {31'd0, busy},     32'd0);
        checkOutput({tag, "_ratio_en"}, {31'd0, ratio_en}, 32'd0);
        checkOutput({tag, "_sck"},      {31'd0, sck},      32'd0);
        checkOutput({tag, "_mosi"},     {31'd0, mosi},     32'd0);
        checkOutput({tag, "_ss_n"},     {31'd0, ss_n},     32'd1);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of transfers.
    initial begin
        int base;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        arst_n = 1'b1;
        en     = 1'b1;
        #1 checkOutput("ready_at_release", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        checkOutput("ready_after_release", {31'd0, tx_ready}, 32'd1);

        {cpol, cpha} = MODE0;
        ratio = 0;
        slvQ.push_back(8'h3C);
        applyStimulus(8'hA5, 8'h3C, 1'b1, "mode0");
        waitRx(1, "mode0");
        checkOutput("mode0_mosi_bits", {24'd0, slvRx}, 32'hA5);
        checkOutput("mode0_sck_toggles", sckToggles, 32'd16);
        checkOutput("mode0_ss_low_ticks", lowTicks, 32'd18);
        checkOutput("mode0_sck_idle_after", {31'd0, sck}, 32'd0);

        ratio = 2;
        for (int i = 0; i < 3; i++) begin
            {cpol, cpha} = modes[i];
            repeat (3) @(negedge clk);
            checkOutput($sformatf("mode%0d_sck_idle_before", i + 1), {31'd0, sck}, {31'd0, cpol});
            base = rxCount;
            slvQ.push_back(8'h81);
            applyStimulus(8'h81, 8'h81, 1'b1, $sformatf("mode%0d", i + 1));
            waitRx(base + 1, $sformatf("mode%0d", i + 1));
            checkOutput($sformatf("mode%0d_mosi_bits", i + 1), {24'd0, slvRx}, 32'h81);
            checkOutput($sformatf("mode%0d_sck_idle_after", i + 1), {31'd0, sck}, {31'd0, cpol});
        end

        {cpol, cpha} = MODE3;
        ratio = 0;
        base  = rxCount;
        slvQ.push_back(8'h00);
        applyStimulus(8'hFF, 8'h00, 1'b0, "abort");
        waitTicks(5, "abort");
        en = 1'b0;
        @(negedge clk);
        checkOutput("abort_ss_n", {31'd0, ss_n}, 32'd1);
        checkOutput("abort_sck", {31'd0, sck}, 32'd1);
        checkOutput("abort_ratio_en", {31'd0, ratio_en}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_tx_ready", {31'd0, tx_ready}, 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("abort_no_rx_valid", rxCount, base);
        en = 1'b1;
        slvQ.push_back(8'h96);
        applyStimulus(8'h55, 8'h96, 1'b1, "after_abort");
        waitRx(base + 1, "after_abort");
        checkOutput("after_abort_mosi_bits", {24'd0, slvRx}, 32'h55);

        {cpol, cpha} = MODE0;
        ratio = 1;
        base  = rxCount;
        readyViolations = 0;
        slvQ.push_back(8'hED);
        slvQ.push_back(8'hCB);
        applyStimulus(8'h12, 8'hED, 1'b1, "b2b_first");
        tx_data  = 8'h34;
        tx_valid = 1'b1;
        applyStimulus(8'h34, 8'hCB, 1'b1, "b2b_second");
        waitRx(base + 2, "b2b");
        checkOutput("b2b_ss_gap_ge2", {31'd0, (lastGap >= 2)}, 32'd1);
        checkOutput("b2b_ready_low_while_selected", readyViolations, 32'd0);
        checkOutput("b2b_second_mosi_bits", {24'd0, slvRx}, 32'h34);

        ratio = 0;
        slvQ.push_back(8'hAA);
        applyStimulus(8'hF0, 8'h00, 1'b0, "async_reset");
        waitTicks(8, "async_reset");
        #2 arst_n = 1'b0;
        #1 checkResetOutputs("async_reset");
        @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        base = rxCount;
        slvQ.push_back(8'hE1);
        applyStimulus(8'h0F, 8'hE1, 1'b1, "after_reset");
        waitRx(base + 1, "after_reset");
        checkOutput("after_reset_mosi_bits", {24'd0, slvRx}, 32'h0F);

`ifdef SPI_LOOPBACK_EN
        base     = rxCount;
        loopback = 1'b1;
        slvQ.push_back(8'h00);
        applyStimulus(8'hC3, 8'hC3, 1'b1, "loopback");
        loopback = 1'b0;
        waitRx(base + 1, "loopback");
`endif

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
